// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write of page P to TRIGGER_ADDR copies LEN bytes from $P00.. into PPU OAMDATA.
// Latency: 1 halt cycle + optional align cycle + 2 cycles per byte; done_o follows the final write by one cycle.
// Backpressure: the CPU is stalled via cpu_halt_o for the whole transfer; OAM_DMA_ABORT_EN adds abort_i.
module oam_dma #(
    parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
    parameter logic [2:0]  OAM_REG      = 3'd4,
    parameter int          LEN          = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr_i,
    input  logic [7:0]  cpu_data_i,
    input  logic        cpu_wr_i,
`ifdef OAM_DMA_ABORT_EN
    input  logic        abort_i,
`endif
    output logic        cpu_halt_o,
    output logic [15:0] mem_addr_o,
    output logic        mem_rd_o,
    input  logic [7:0]  mem_data_i,
    output logic        ppu_cs_o,
    output logic        ppu_rw_o,
    output logic [2:0]  ppu_addr_o,
    output logic [7:0]  ppu_data_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

    localparam logic [7:0] LAST = 8'(LEN - 1);

    state_t     state, state_nxt;
    logic       parity;
    logic [7:0] page, page_nxt;
    logic [7:0] idx, idx_nxt;
    logic       done_nxt;
    logic       abort;

`ifdef OAM_DMA_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            parity <= 1'b0;
            page   <= 8'h00;
            idx    <= 8'h00;
            done_o <= 1'b0;
        end else begin
            state  <= state_nxt;
            parity <= ~parity;
            page   <= page_nxt;
            idx    <= idx_nxt;
            done_o <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        page_nxt   = page;
        idx_nxt    = idx;
        done_nxt   = 1'b0;
        cpu_halt_o = 1'b0;
        busy_o     = 1'b0;
        mem_rd_o   = 1'b0;
        mem_addr_o = 16'h0000;
        ppu_cs_o   = 1'b0;
        ppu_rw_o   = 1'b1;
        ppu_addr_o = 3'd0;
        ppu_data_o = 8'h00;
        case (state)
            IDLE: begin
                if (cpu_wr_i && (cpu_addr_i == TRIGGER_ADDR)) begin
                    page_nxt  = cpu_data_i;
                    idx_nxt   = 8'h00;
                    state_nxt = HALT;
                end
            end
            HALT: begin
                cpu_halt_o = 1'b1;
                busy_o     = 1'b1;
                // An even HALT gets one ALIGN cycle so the first READ always lands on an even cycle.
                if (abort)
                    state_nxt = IDLE;
                else if (!parity)
                    state_nxt = ALIGN;
                else
                    state_nxt = READ;
            end
            ALIGN: begin
                cpu_halt_o = 1'b1;
                busy_o     = 1'b1;
                state_nxt  = abort ? IDLE : READ;
            end
            READ: begin
                cpu_halt_o = 1'b1;
                busy_o     = 1'b1;
                mem_rd_o   = 1'b1;
                mem_addr_o = {page, idx};
                state_nxt  = abort ? IDLE : WRITE;
            end
            WRITE: begin
                cpu_halt_o = 1'b1;
                busy_o     = 1'b1;
                ppu_cs_o   = 1'b1;
                ppu_rw_o   = 1'b0;
                ppu_addr_o = OAM_REG;
                ppu_data_o = mem_data_i;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (idx == LAST) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    idx_nxt   = idx + 8'd1;
                    state_nxt = READ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: source memory returns low address byte ^ $A5 one cycle after a read.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cpu_addr_i = 16'h0000;
    logic [7:0]  cpu_data_i = 8'h00;
    logic        cpu_wr_i = 1'b0;
`ifdef OAM_DMA_ABORT_EN
    logic        abort_i = 1'b0;
`endif
    logic        cpu_halt_o;
    logic [15:0] mem_addr_o;
    logic        mem_rd_o;
    logic [7:0]  mem_data_i = 8'h00;
    logic        ppu_cs_o;
    logic        ppu_rw_o;
    logic [2:0]  ppu_addr_o;
    logic [7:0]  ppu_data_o;
    logic        busy_o;
    logic        done_o;

    oam_dma dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .cpu_wr_i   (cpu_wr_i),
`ifdef OAM_DMA_ABORT_EN
        .abort_i    (abort_i),
`endif
        .cpu_halt_o (cpu_halt_o),
        .mem_addr_o (mem_addr_o),
        .mem_rd_o   (mem_rd_o),
        .mem_data_i (mem_data_i),
        .ppu_cs_o   (ppu_cs_o),
        .ppu_rw_o   (ppu_rw_o),
        .ppu_addr_o (ppu_addr_o),
        .ppu_data_o (ppu_data_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Cycle counter mirrors the parity definition: reset to 0, advances every clk.
    int unsigned cyc;
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        if (mem_rd_o) mem_data_i <= mem_addr_o[7:0] ^ 8'hA5;
    end

    // Per-transfer statistics, cleared on each rising edge of busy_o.
    logic [7:0]  exp_page = 8'h00;
    int          halt_cnt = 0, rd_cnt = 0, wr_cnt = 0, rd_err = 0, wr_err = 0;
    int          first_par = -1;
    logic [15:0] last_rd = 16'h0000;
    int          done_cnt = 0, done_err = 0, flag_err = 0, idle_err = 0;
    bit          prev_busy = 1'b0, prev_wr = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            if (busy_o && !prev_busy) begin
                halt_cnt = 0; rd_cnt = 0; wr_cnt = 0; rd_err = 0; wr_err = 0; first_par = -1;
            end
            if (cpu_halt_o) halt_cnt++;
            if (busy_o !== cpu_halt_o) flag_err++;
            if (mem_rd_o === 1'b1) begin
                if (rd_cnt == 0) first_par = int'(cyc[0]);
                if (mem_addr_o !== {exp_page, rd_cnt[7:0]}) rd_err++;
                last_rd = mem_addr_o;
                rd_cnt++;
            end
            if (done_o === 1'b1) begin
                done_cnt++;
                if (!prev_wr) done_err++;
            end
            prev_wr = 1'b0;
            if (ppu_cs_o === 1'b1 && ppu_rw_o === 1'b0) begin
                if (ppu_addr_o !== 3'd4 || ppu_data_o !== (wr_cnt[7:0] ^ 8'hA5)) wr_err++;
                wr_cnt++;
                prev_wr = 1'b1;
            end
            if (!busy_o && (mem_rd_o !== 1'b0 || mem_addr_o !== 16'h0 || ppu_cs_o !== 1'b0 ||
                            ppu_rw_o !== 1'b1 || ppu_addr_o !== 3'd0 || ppu_data_o !== 8'h0))
                idle_err++;
            prev_busy = busy_o;
        end else begin
            prev_busy = 1'b0;
            prev_wr   = 1'b0;
        end
    end

    bit tmo;

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr_i = a; cpu_data_i = d; cpu_wr_i = 1'b1;
        @(negedge clk);
        cpu_wr_i = 1'b0; cpu_addr_i = 16'h0000; cpu_data_i = 8'h00;
    endtask

    task automatic trigger(input logic [7:0] page, input bit par);
        exp_page = page;
        @(negedge clk);
        for (int i = 0; i < 4 && cyc[0] !== par; i++) @(negedge clk);
        cpu_write(16'h4014, page);
    endtask

    task automatic wait_idle();
        tmo = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (!busy_o) begin tmo = 1'b0; break; end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        total++; if (cpu_halt_o !== 1'b0) begin bad++; $display("FAIL reset_halt got=%b want=0", cpu_halt_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done_o); end
        total++; if (mem_rd_o !== 1'b0 || mem_addr_o !== 16'h0) begin bad++; $display("FAIL reset_mem got=%b/%h want=0/0000", mem_rd_o, mem_addr_o); end
        total++; if (ppu_cs_o !== 1'b0 || ppu_rw_o !== 1'b1 || ppu_addr_o !== 3'd0 || ppu_data_o !== 8'h0) begin
            bad++; $display("FAIL reset_ppu got=%b%b/%0d/%h want=01/0/00", ppu_cs_o, ppu_rw_o, ppu_addr_o, ppu_data_o);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_even_trigger();
        int d0 = done_cnt;
        trigger(8'h02, 1'b0);
        wait_idle();
        total++; if (tmo) begin bad++; $display("FAIL even_timeout got=busy want=idle"); end
        total++; if (wr_cnt != 256 || wr_err != 0) begin bad++; $display("FAIL even_writes got=%0d err=%0d want=256 err=0", wr_cnt, wr_err); end
        total++; if (rd_cnt != 256 || rd_err != 0) begin bad++; $display("FAIL even_reads got=%0d err=%0d want=256 err=0", rd_cnt, rd_err); end
        total++; if (halt_cnt != 513) begin bad++; $display("FAIL even_halt got=%0d want=513", halt_cnt); end
        total++; if (done_cnt - d0 != 1 || done_err != 0) begin bad++; $display("FAIL even_done got=%0d err=%0d want=1 err=0", done_cnt - d0, done_err); end
        total++; if (first_par != 0) begin bad++; $display("FAIL even_first_rd_parity got=%0d want=0", first_par); end
    endtask

    task automatic test_odd_trigger();
        int d0 = done_cnt;
        trigger(8'h02, 1'b1);
        wait_idle();
        total++; if (tmo) begin bad++; $display("FAIL odd_timeout got=busy want=idle"); end
        total++; if (halt_cnt != 514) begin bad++; $display("FAIL odd_halt got=%0d want=514", halt_cnt); end
        total++; if (first_par != 0) begin bad++; $display("FAIL odd_first_rd_parity got=%0d want=0", first_par); end
        total++; if (wr_cnt != 256 || wr_err != 0 || done_cnt - d0 != 1) begin
            bad++; $display("FAIL odd_xfer got=%0d err=%0d done=%0d want=256/0/1", wr_cnt, wr_err, done_cnt - d0);
        end
    endtask

    task automatic test_page_ff();
        trigger(8'hFF, 1'b0);
        wait_idle();
        total++; if (last_rd !== 16'hFFFF) begin bad++; $display("FAIL pageff_last got=%h want=ffff", last_rd); end
        total++; if (rd_err != 0 || rd_cnt != 256) begin bad++; $display("FAIL pageff_range got=%0d err=%0d want=256 err=0", rd_cnt, rd_err); end
    endtask

    task automatic test_retrigger();
        int d0 = done_cnt;
        trigger(8'h02, 1'b0);
        repeat (50) @(negedge clk);
        cpu_write(16'h4014, 8'h03);
        repeat (7) @(negedge clk);
        cpu_write(16'h2004, 8'h77);
        wait_idle();
        total++; if (rd_err != 0 || rd_cnt != 256) begin bad++; $display("FAIL retrig_reads got=%0d err=%0d want=256 err=0", rd_cnt, rd_err); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL retrig_done got=%0d want=1", done_cnt - d0); end
        total++; if (wr_err != 0 || wr_cnt != 256) begin bad++; $display("FAIL retrig_writes got=%0d err=%0d want=256 err=0", wr_cnt, wr_err); end
    endtask

    task automatic test_mid_reset();
        int d0;
        trigger(8'h02, 1'b0);
        repeat (1 + 2 * 100) @(negedge clk);
        total++; if (busy_o !== 1'b1 || wr_cnt < 99) begin bad++; $display("FAIL midrst_pre got=%b/%0d want=1/>=99", busy_o, wr_cnt); end
        rst = 1'b0;
        #1;
        total++; if (busy_o !== 1'b0 || cpu_halt_o !== 1'b0 || done_o !== 1'b0) begin
            bad++; $display("FAIL midrst_flags got=%b%b%b want=000", busy_o, cpu_halt_o, done_o);
        end
        total++; if (mem_rd_o !== 1'b0 || mem_addr_o !== 16'h0 || ppu_cs_o !== 1'b0 || ppu_rw_o !== 1'b1 ||
                     ppu_addr_o !== 3'd0 || ppu_data_o !== 8'h0) begin
            bad++; $display("FAIL midrst_bus got=%b/%h/%b%b/%0d/%h want=0/0000/01/0/00",
                            mem_rd_o, mem_addr_o, ppu_cs_o, ppu_rw_o, ppu_addr_o, ppu_data_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        d0 = done_cnt;
        trigger(8'h04, 1'b0);
        wait_idle();
        total++; if (tmo || rd_err != 0 || rd_cnt != 256 || last_rd !== 16'h04FF) begin
            bad++; $display("FAIL midrst_page4 got=%0d err=%0d last=%h want=256/0/04ff", rd_cnt, rd_err, last_rd);
        end
        total++; if (wr_cnt != 256 || wr_err != 0 || done_cnt - d0 != 1) begin
            bad++; $display("FAIL midrst_writes got=%0d err=%0d done=%0d want=256/0/1", wr_cnt, wr_err, done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        bit seen = 1'b0;
        trigger(8'h02, 1'b0);
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin seen = 1'b1; break; end
        end
        total++; if (!seen) begin bad++; $display("FAIL b2b_first_done got=0 want=1"); end
        exp_page = 8'h05;
        cpu_write(16'h4014, 8'h05);
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", busy_o); end
        wait_idle();
        total++; if (tmo || done_cnt - d0 != 2 || rd_err != 0 || wr_cnt != 256) begin
            bad++; $display("FAIL b2b_second got=done%0d err%0d wr%0d want=2/0/256", done_cnt - d0, rd_err, wr_cnt);
        end
    endtask

`ifdef OAM_DMA_ABORT_EN
    task automatic test_abort();
        int d0 = done_cnt;
        bit hit = 1'b0;
        trigger(8'h02, 1'b0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (ppu_cs_o === 1'b1 && ppu_rw_o === 1'b0 && ppu_data_o === (8'd10 ^ 8'hA5)) begin hit = 1'b1; break; end
        end
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        total++; if (!hit || busy_o !== 1'b0) begin bad++; $display("FAIL abort_idle got=hit%b busy%b want=1/0", hit, busy_o); end
        repeat (3) @(negedge clk);
        total++; if (wr_cnt != 11 || wr_err != 0) begin bad++; $display("FAIL abort_writes got=%0d err=%0d want=11 err=0", wr_cnt, wr_err); end
        total++; if (done_cnt != d0) begin bad++; $display("FAIL abort_done got=%0d want=0", done_cnt - d0); end
    endtask
`endif

    initial begin
        test_reset();
        test_even_trigger();
        test_odd_trigger();
        test_page_ff();
        test_retrigger();
        test_mid_reset();
        test_back_to_back();
`ifdef OAM_DMA_ABORT_EN
        test_abort();
`endif
        total++; if (idle_err != 0 || flag_err != 0 || done_err != 0) begin
            bad++; $display("FAIL global_monitor got=idle%0d flag%0d done%0d want=0/0/0", idle_err, flag_err, done_err);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
